// File: rtl/ctrl_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, FSM states,
// instruction field layout at default widths and control-word bit positions.
package ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_CW_W   = 15;
  localparam int DEF_INSTR_W = DEF_CW_W + 2 + DEF_ADDR_W;

  // Instruction fields at default widths: {cw, op, tgt}
  localparam int TGT_LSB = 0;
  localparam int OP_LSB  = DEF_ADDR_W;
  localparam int OP_W    = 2;
  localparam int CWF_LSB = DEF_ADDR_W + 2;

  // Control word layout seen by the compare/swap datapath
  localparam int CW_ALU_LSB  = 13;
  localparam int CW_ALU_W    = 2;
  localparam int CW_MUXA_LSB = 9;
  localparam int CW_MUXA_W   = 4;
  localparam int CW_MUXB_LSB = 5;
  localparam int CW_MUXB_W   = 4;
  localparam int CW_REG_LSB  = 1;
  localparam int CW_REG_W    = 4;
  localparam int CW_WR_BIT   = 0;

  typedef enum logic [1:0] {
    OP_NEXT     = 2'b00,
    OP_BR_MAYOR = 2'b01,
    OP_JUMP     = 2'b10,
    OP_HALT     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ucode_ram.sv
// Microprogram store: register array with one synchronous write port and one
// combinational read port. Not reset, so a loaded program survives rst.
module ucode_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ctrl_sequencer.sv
// Programmable microcode sequencer driving the compare/swap datapath control word.
// Optional RUN-cycle watchdog is built when SEQ_WATCHDOG_EN is defined.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CW_W   = DEF_CW_W,
  parameter int WD_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     mayor,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [CW_W+2+ADDR_W-1:0] prog_data,
  output logic [CW_W-1:0]          o_signal,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        pc_o
);

  localparam int IW = CW_W + 2 + ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;

  logic [IW-1:0]     instr;
  logic [CW_W-1:0]   cw;
  op_e               op;
  logic [ADDR_W-1:0] tgt, pc_inc;
  logic              wd_expire;

  ucode_ram #(.ADDR_W(ADDR_W), .DATA_W(IW)) u_ram (
    .clk     (clk),
    .we_i    (prog_we && (state_q == ST_IDLE)),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (instr)
  );

  assign cw     = instr[IW-1 -: CW_W];
  assign op     = op_e'(instr[ADDR_W+1:ADDR_W]);
  assign tgt    = instr[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef SEQ_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;

  // Counts RUN cycles; held at zero outside RUN so every run starts fresh
  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_RUN) wd_d = wd_q + 8'd1;
    else                   wd_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign wd_expire = (state_q == ST_RUN) && (wd_q == 8'(WD_MAX - 1));
`else
  logic wd_unused;
  assign wd_unused = ^8'(WD_MAX);
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        // abort beats everything; a HALT on the last allowed cycle still ends clean
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (op == OP_HALT) begin
          state_d = ST_DONE;
        end else if (wd_expire) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          unique case (op)
            OP_NEXT:     pc_d = pc_inc;
            OP_BR_MAYOR: pc_d = mayor ? tgt : pc_inc;
            OP_JUMP:     pc_d = tgt;
            default:     pc_d = pc_q;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign o_signal = busy ? cw : '0;
  assign err      = err_q;
  assign pc_o     = pc_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a per-instruction reference model
// predicts every RUN/DONE cycle; honours SEQ_WATCHDOG_EN with WD_MAX=8.
module tb_ctrl_sequencer;

  localparam int ADDR_W = 4;
  localparam int CW_W   = 15;
  localparam int IW     = CW_W + 2 + ADDR_W;
  localparam int DEPTH  = 16;
  localparam int WD_MAX = 8;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, abort = 1'b0, mayor = 1'b0, prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [IW-1:0]     prog_data = '0;
  logic [CW_W-1:0]   o_signal;
  logic              busy, done, err;
  logic [ADDR_W-1:0] pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IW-1:0]   mem_m [DEPTH];
  logic [ADDR_W-1:0] obs_pc [$];
  logic [CW_W-1:0]   obs_cw [$];

  ctrl_sequencer #(.ADDR_W(ADDR_W), .CW_W(CW_W), .WD_MAX(WD_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mayor(mayor),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .o_signal(o_signal), .busy(busy), .done(done), .err(err), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk(input logic [CW_W-1:0] cw, input logic [1:0] op,
                                       input logic [ADDR_W-1:0] tgt);
    return {cw, op, tgt};
  endfunction

  task automatic wr(input int a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_data = d;
    mem_m[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Starts a run from IDLE and checks every cycle against the model.
  // mmode: 0/1 fixed mayor, 2 random. abort_at/we_at: RUN cycle index or -1.
  task automatic run_check(input string nm, input int mmode, input int abort_at,
                           input int we_at, input int max_cyc, output int ncyc);
    int pc; bit fin; bit eerr; logic [IW-1:0] ins; logic [1:0] op; logic [ADDR_W-1:0] tg;
    obs_pc.delete(); obs_cw.delete();
    pc = 0; fin = 0; eerr = 0; ncyc = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (!fin && ncyc < max_cyc) begin
      mayor = (mmode == 2) ? 1'($urandom_range(0, 1)) : 1'(mmode);
      abort = (ncyc == abort_at);
      prog_we = (ncyc == we_at); prog_addr = 4'd1; prog_data = '1;
      ins = mem_m[pc]; op = ins[ADDR_W+1:ADDR_W]; tg = ins[ADDR_W-1:0];
      n_tests++;
      if ({busy, done, pc_o, o_signal} !== {1'b1, 1'b0, 4'(pc), ins[IW-1 -: CW_W]}) begin
        n_fail++;
        $display("FAIL %s run cyc %0d: busy/done/pc/cw got %b/%b/%0d/%h want 1/0/%0d/%h",
                 nm, ncyc, busy, done, pc_o, o_signal, pc, ins[IW-1 -: CW_W]);
      end
      obs_pc.push_back(pc_o); obs_cw.push_back(o_signal);
      if (abort) begin fin = 1; eerr = 1; end
      else if (op == 2'b11) fin = 1;
      else if (WD_ON && ncyc + 1 == WD_MAX) begin fin = 1; eerr = 1; end
      else if (op == 2'b00) pc = (pc + 1) % DEPTH;
      else if (op == 2'b01) pc = mayor ? int'(tg) : (pc + 1) % DEPTH;
      else pc = int'(tg);
      ncyc++;
      tick();
      abort = 1'b0; prog_we = 1'b0;
    end
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no end within %0d cycles", nm, max_cyc);
      abort = 1'b1; tick(); abort = 1'b0; tick();
    end else begin
      n_tests++;
      if ({busy, done, err, o_signal, pc_o} !== {1'b0, 1'b1, eerr, 15'h0, 4'(pc)}) begin
        n_fail++;
        $display("FAIL %s done cyc: busy/done/err/cw/pc got %b/%b/%b/%h/%0d want 0/1/%b/0000/%0d",
                 nm, busy, done, err, o_signal, pc_o, eerr, pc);
      end
      tick();
      n_tests++;
      if ({busy, done, err, o_signal} !== {1'b0, 1'b0, eerr, 15'h0}) begin
        n_fail++;
        $display("FAIL %s idle after done: busy/done/err/cw got %b/%b/%b/%h want 0/0/%b/0000",
                 nm, busy, done, err, o_signal, eerr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({busy, done, err, pc_o, o_signal} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: busy/done/err/pc/cw got %b/%b/%b/%0d/%h want all 0",
                 i, busy, done, err, pc_o, o_signal);
      end
      tick();
    end
    for (int i = 0; i < DEPTH; i++) wr(i, mk(15'($urandom), 2'b00, 4'd0));
  endtask

  task automatic test_linear();
    int n;
    wr(0, mk(15'h0240, 2'b00, 4'd0));
    wr(1, mk(15'h0249, 2'b00, 4'd0));
    wr(2, mk(15'h0000, 2'b11, 4'd0));
    run_check("linear", 0, -1, -1, 20, n);
    n_tests++;
    if (n != 3 || obs_cw.size() != 3 || obs_cw[0] !== 15'h0240 || obs_cw[1] !== 15'h0249 ||
        obs_cw[2] !== 15'h0000) begin
      n_fail++;
      $display("FAIL linear_seq: got %0d busy cycles, want 3 with cw 0240,0249,0000", n);
    end
  endtask

  task automatic test_branch();
    int n;
    wr(0, mk(15'h0111, 2'b01, 4'd5));
    wr(1, mk(15'h0222, 2'b11, 4'd0));
    wr(5, mk(15'h0460, 2'b11, 4'd0));
    for (int m = 1; m >= 0; m--) begin
      run_check(m ? "branch_taken" : "branch_fall", m, -1, -1, 20, n);
      n_tests++;
      if (n != 2 || obs_pc[0] !== 4'd0 || obs_pc[1] !== (m ? 4'd5 : 4'd1)) begin
        n_fail++;
        $display("FAIL branch_pcseq mayor=%0d: got %0d cycles, pc1=%0d want 2 cycles, pc1=%0d",
                 m, n, (obs_pc.size() > 1) ? obs_pc[1] : 4'd0, m ? 5 : 1);
      end
    end
  endtask

  task automatic test_wrap_abort();
    int n;
    wr(0, mk(15'h0333, 2'b10, 4'd15));
    wr(15, mk(15'h0444, 2'b00, 4'd0));
    run_check("wrap_abort", 2, 6, -1, 20, n);
    n_tests++;
    if (n != 7 || obs_pc[0] !== 4'd0 || obs_pc[1] !== 4'd15 || obs_pc[2] !== 4'd0 ||
        obs_pc[3] !== 4'd15) begin
      n_fail++;
      $display("FAIL wrap_pcseq: got %0d cycles, want 7 alternating 0,15", n);
    end
  endtask

  task automatic test_write_protect();
    int n;
    wr(0, mk(15'h0240, 2'b00, 4'd0));
    wr(1, mk(15'h0249, 2'b00, 4'd0));
    wr(2, mk(15'h0000, 2'b11, 4'd0));
    run_check("wp_run", 0, -1, 1, 20, n);
    run_check("wp_rerun", 0, -1, -1, 20, n);
    n_tests++;
    if (obs_cw.size() < 2 || obs_cw[1] !== 15'h0249) begin
      n_fail++;
      $display("FAIL write_protect: addr1 cw got %h want 0249",
               (obs_cw.size() > 1) ? obs_cw[1] : 15'h0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // write and start in the same IDLE cycle: new word must be fetched first
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = mk(15'h5A5A, 2'b11, 4'd0);
    mem_m[0] = prog_data;
    run_check("wr_start_same", 0, -1, -1, 10, n);
    run_check("back_to_back", 1, -1, -1, 10, n);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, mk(15'($urandom), 2'($urandom_range(0, 3)), 4'($urandom)));
      run_check("random", 2, int'($urandom_range(3, 30)), -1, 40, n);
    end
  endtask

  task automatic test_watchdog();
    int n;
    wr(0, mk(15'h1234, 2'b10, 4'd0));
    run_check("watchdog", 2, WD_ON ? -1 : 50, -1, 60, n);
    n_tests++;
    if (n != (WD_ON ? WD_MAX : 51)) begin
      n_fail++;
      $display("FAIL watchdog_len: got %0d RUN cycles want %0d", n, WD_ON ? WD_MAX : 51);
    end
  endtask

  task automatic test_rst_mid_run();
    wr(0, mk(15'h0777, 2'b10, 4'd3));
    wr(3, mk(15'h0888, 2'b10, 4'd0));
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_run_pre: busy got %b want 1", busy);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({busy, done, err, pc_o, o_signal} !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_run cyc %0d: busy/done/err/pc/cw got %b/%b/%b/%0d/%h want all 0",
                 i, busy, done, err, pc_o, o_signal);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_branch();
    test_wrap_abort();
    test_write_protect();
    test_back_to_back();
    test_random();
    test_watchdog();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
